forward_hazard_unit: RTL and testbench

- Control-side counterpart of the 3-to-1 operand select muxes in the EX stage.
- Tracks destination-register and writeback info for the ID/EX, EX/MEM and MEM/WB stages in internal shadow registers.
- Generates the 2-bit select codes for the ALU operand A and B muxes.
- Detects load-use hazards and requests a one-cycle stall with a bubble insert.

---
 rtl/forward_hazard_unit_if.sv | 27 ++
 rtl/forward_hazard_unit.sv | 92 +++++++++
 tb/tb_forward_hazard_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/forward_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The pipeline drives the ID-stage fields; the unit returns the mux selects and stall control.
interface forward_hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRt;
  logic [REG_ADDR_W-1:0] ID_Dest;
  logic                  ID_RegWrite;
  logic                  ID_MemRead;
  logic                  Flush;
  logic [1:0]            ForwardA;
  logic [1:0]            ForwardB;
  logic                  Stall;
  logic                  Bubble;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Dest, ID_RegWrite, ID_MemRead, Flush,
    input  ForwardA, ForwardB, Stall, Bubble
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Dest, ID_RegWrite, ID_MemRead, Flush,
    output ForwardA, ForwardB, Stall, Bubble
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall detection, driven from
// shadow copies of the destination/writeback info held in ID/EX, EX/MEM and MEM/WB.
module forward_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                 Clk,
  input  logic                 Rst,
  forward_hazard_unit_if.slave hz
);

  logic [REG_ADDR_W-1:0] r_ex_rs;
  logic [REG_ADDR_W-1:0] r_ex_rt;
  logic [REG_ADDR_W-1:0] r_ex_dest;
  logic                  r_ex_regwrite;
  logic                  r_ex_memread;
  logic [REG_ADDR_W-1:0] r_mem_dest;
  logic                  r_mem_regwrite;
  logic [REG_ADDR_W-1:0] r_wb_dest;
  logic                  r_wb_regwrite;

  logic w_hazard;
  logic w_bubble;
  logic w_mem_valid;
  logic w_wb_valid;

  // A register-0 destination is never a real producer.
  assign w_mem_valid = r_mem_regwrite && (r_mem_dest != '0);
  assign w_wb_valid  = r_wb_regwrite  && (r_wb_dest  != '0);

  assign w_hazard = r_ex_memread && (r_ex_dest != '0) &&
                    ((r_ex_dest == hz.ID_Rs) || (hz.ID_UsesRt && (r_ex_dest == hz.ID_Rt)));
  assign w_bubble = w_hazard || hz.Flush;

  assign hz.Stall  = w_hazard && !hz.Flush;
  assign hz.Bubble = w_bubble;

  // Operand 0 is A (rs), operand 1 is B (rt); EX/MEM wins over MEM/WB.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [REG_ADDR_W-1:0] w_src;
      logic [1:0]            w_sel;

      assign w_src = (gi == 0) ? r_ex_rs : r_ex_rt;

      always_comb begin
        w_sel = 2'b00;
        if (w_mem_valid && (r_mem_dest == w_src)) begin
          w_sel = 2'b10;
        end else if (w_wb_valid && (r_wb_dest == w_src)) begin
          w_sel = 2'b01;
        end
      end
    end
  endgenerate

  assign hz.ForwardA = g_fwd[0].w_sel;
  assign hz.ForwardB = g_fwd[1].w_sel;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_dest      <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_dest     <= '0;
      r_mem_regwrite <= 1'b0;
      r_wb_dest      <= '0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_wb_dest      <= r_mem_dest;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_dest     <= r_ex_dest;
      r_mem_regwrite <= r_ex_regwrite;
      if (w_bubble) begin
        r_ex_rs       <= '0;
        r_ex_rt       <= '0;
        r_ex_dest     <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_rs       <= hz.ID_Rs;
        r_ex_rt       <= hz.ID_Rt;
        r_ex_dest     <= hz.ID_Dest;
        r_ex_regwrite <= hz.ID_RegWrite;
        r_ex_memread  <= hz.ID_MemRead;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit: a cycle-indexed issue log model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_forward_hazard_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } rec_t;

  logic Clk;
  logic Rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   slot_no = 0;

  forward_hazard_unit_if #(.REG_ADDR_W(5)) ifc ();

  forward_hazard_unit #(.REG_ADDR_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .hz  (ifc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: log_q[k] is what entered EX at edge k. Now EX = log[t], MEM = log[t-1],
  // WB = log[t-2]; anything issued before the last reset reads as empty.
  rec_t log_q [0:1023];
  int   t     = 0;
  int   epoch = 1;

  function automatic rec_t get(int k);
    rec_t z;
    z = '0;
    if (k < epoch || k < 0 || k > 1023) return z;
    return log_q[k];
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] src);
    rec_t m, w;
    m = get(t - 1);
    w = get(t - 2);
    if (m.rw && m.dest != 0 && m.dest == src) return 2'd2;
    if (w.rw && w.dest != 0 && w.dest == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic exp_hazard();
    rec_t e;
    e = get(t);
    return e.mr && e.dest != 0 &&
           (e.dest == ifc.ID_Rs || (ifc.ID_UsesRt && e.dest == ifc.ID_Rt));
  endfunction

  function automatic rec_t id_rec();
    rec_t r;
    r.rs   = ifc.ID_Rs;
    r.rt   = ifc.ID_Rt;
    r.dest = ifc.ID_Dest;
    r.rw   = ifc.ID_RegWrite;
    r.mr   = ifc.ID_MemRead;
    return r;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      epoch <= t + 1;
    end else begin
      log_q[t + 1] <= (exp_hazard() || ifc.Flush) ? rec_t'('0) : id_rec();
      t            <= t + 1;
    end
  end

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge Clk) begin
    chk("model ForwardA", ifc.ForwardA, exp_fwd(get(t).rs));
    chk("model ForwardB", ifc.ForwardB, exp_fwd(get(t).rt));
    chk("model Stall",    {1'b0, ifc.Stall},  {1'b0, exp_hazard() && !ifc.Flush});
    chk("model Bubble",   {1'b0, ifc.Bubble}, {1'b0, exp_hazard() || ifc.Flush});
  end

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                        input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
    ifc.ID_Rs       = rs;
    ifc.ID_Rt       = rt;
    ifc.ID_UsesRt   = ut;
    ifc.ID_Dest     = dest;
    ifc.ID_RegWrite = rw;
    ifc.ID_MemRead  = mr;
    ifc.Flush       = fl;
  endtask

  // One pipeline cycle: new ID contents just after the edge, outputs sampled at the falling edge.
  task automatic slot(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                      input logic [4:0] dest, input logic rw, input logic mr, input logic fl);
    @(posedge Clk);
    #1;
    set_id(rs, rt, ut, dest, rw, mr, fl);
    @(negedge Clk);
    slot_no++;
    $display("[TB] slot %0d: ID rs=%0d rt=%0d ut=%0d dest=%0d rw=%0d mr=%0d fl=%0d -> A=%0d B=%0d stall=%0d bubble=%0d",
             slot_no, rs, rt, ut, dest, rw, mr, fl,
             ifc.ForwardA, ifc.ForwardB, ifc.Stall, ifc.Bubble);
  endtask

  task automatic nop();
    slot(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    nop();
    nop();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Rst = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    chk("reset ForwardA", ifc.ForwardA, 2'd0);
    chk("reset Stall",    {1'b0, ifc.Stall}, 2'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;

    // Reset mid-run: add $3; lw $3,0($3); add $3,$3 stalls behind the load.
    slot(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    slot(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    slot(5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("pre-reset ForwardA", ifc.ForwardA, 2'd2);
    chk("pre-reset Stall",    {1'b0, ifc.Stall}, 2'd1);
    #1;
    Rst = 1'b0;
    #1;
    chk("async reset ForwardA", ifc.ForwardA, 2'd0);
    chk("async reset ForwardB", ifc.ForwardB, 2'd0);
    chk("async reset Stall",    {1'b0, ifc.Stall},  2'd0);
    chk("async reset Bubble",   {1'b0, ifc.Bubble}, 2'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    set_id(5'd3, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge Clk);
    nop();
    chk("post-reset ForwardA", ifc.ForwardA, 2'd0);
    chk("post-reset ForwardB", ifc.ForwardB, 2'd0);
    drain();

    // EX/MEM forward: add $3; sub $6,$3,$5
    slot(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    slot(5'd3, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    nop();
    chk("exmem ForwardA", ifc.ForwardA, 2'd2);
    chk("exmem ForwardB", ifc.ForwardB, 2'd0);
    drain();

    // MEM/WB forward: add $3; nop; or $8,$3,$7
    slot(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    nop();
    slot(5'd3, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    chk("memwb ForwardA", ifc.ForwardA, 2'd1);
    chk("memwb ForwardB", ifc.ForwardB, 2'd0);
    drain();

    // Priority: add $3; add $3; or $8,$3,$3
    slot(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    slot(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    slot(5'd3, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    nop();
    chk("priority ForwardA", ifc.ForwardA, 2'd2);
    chk("priority ForwardB", ifc.ForwardB, 2'd2);
    drain();

    // Load-use: lw $4; add $9,$4,$5 stalls one cycle, then forwards from MEM/WB.
    slot(5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    slot(5'd4, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("loaduse Stall",  {1'b0, ifc.Stall},  2'd1);
    chk("loaduse Bubble", {1'b0, ifc.Bubble}, 2'd1);
    slot(5'd4, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("loaduse held Stall",  {1'b0, ifc.Stall},  2'd0);
    chk("loaduse held Bubble", {1'b0, ifc.Bubble}, 2'd0);
    nop();
    chk("loaduse ForwardA", ifc.ForwardA, 2'd1);
    chk("loaduse ForwardB", ifc.ForwardB, 2'd0);
    chk("loaduse after Stall", {1'b0, ifc.Stall}, 2'd0);
    drain();

    // rt match without UsesRt does not stall; with UsesRt it does.
    slot(5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    slot(5'd5, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("rt unused Stall", {1'b0, ifc.Stall}, 2'd0);
    drain();
    slot(5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    slot(5'd5, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    chk("rt used Stall", {1'b0, ifc.Stall}, 2'd1);
    drain();

    // Register 0 never forwards or stalls.
    slot(5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    slot(5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    nop();
    chk("r0 ForwardA", ifc.ForwardA, 2'd0);
    chk("r0 ForwardB", ifc.ForwardB, 2'd0);
    drain();
    slot(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    slot(5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("r0 load Stall", {1'b0, ifc.Stall}, 2'd0);
    drain();

    // Flush overrides stall; the discarded add is not forwarded to.
    slot(5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    slot(5'd4, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("flush Stall",  {1'b0, ifc.Stall},  2'd0);
    chk("flush Bubble", {1'b0, ifc.Bubble}, 2'd1);
    nop();
    chk("flush ForwardA", ifc.ForwardA, 2'd0);
    chk("flush ForwardB", ifc.ForwardB, 2'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
